// File: rtl/vend_ctrl.sv
// Vending front-end: two buffered coin slots merged round-robin into the core,
// paced against the core's sell/change response, then motor and hopper sequencing.
// Optional sale counter built only when VEND_CTRL_CNT_EN is defined.
module vend_ctrl #(
    parameter int unsigned MOTOR_CYC  = 4,
    parameter int unsigned HOPPER_CYC = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] coin_a,
    input  logic [1:0] coin_b,
    output logic [1:0] coin_o,
    input  logic       sell_i,
    input  logic [1:0] change_i,
    output logic       motor,
    output logic       hopper,
    output logic       rej_a,
    output logic       rej_b,
    output logic       busy,
    output logic [7:0] vend_cnt
);

    localparam int unsigned W_COIN = 2;
    localparam int unsigned W_TMR  = 8;
    localparam int unsigned W_PROD = 10;

    localparam logic [W_TMR-1:0] MOTOR_LOAD = W_TMR'(MOTOR_CYC);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        CHECK    = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [W_COIN-1:0]   buf_a_q, buf_a_d;
    logic [W_COIN-1:0]   buf_b_q, buf_b_d;
    logic                ptr_q, ptr_d;
    logic [W_COIN-1:0]   coin_o_q, coin_o_d;
    logic [W_COIN-1:0]   chg_q, chg_d;
    logic [W_TMR-1:0]    mtmr_q, mtmr_d;
    logic [W_TMR-1:0]    htmr_q, htmr_d;
    logic                motor_q, motor_d;
    logic                hopper_q, hopper_d;
    logic                rej_a_q, rej_a_d;
    logic                rej_b_q, rej_b_d;
    logic                busy_q, busy_d;

    logic                full_a_c, full_b_c;
    logic                legal_a_c, legal_b_c;
    logic                grant_a_c, grant_b_c;
    logic [W_TMR-1:0]    hop_load_c;

    assign full_a_c  = (buf_a_q != 2'b00);
    assign full_b_c  = (buf_b_q != 2'b00);
    assign legal_a_c = (coin_a == 2'b01) || (coin_a == 2'b10);
    assign legal_b_c = (coin_b == 2'b01) || (coin_b == 2'b10);

    // Hopper run length: change units times cycles per unit, truncated to the timer width
    assign hop_load_c = W_TMR'(W_PROD'(chg_q) * W_PROD'(HOPPER_CYC));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            buf_a_q  <= '0;
            buf_b_q  <= '0;
            ptr_q    <= 1'b0;
            coin_o_q <= '0;
            chg_q    <= '0;
            mtmr_q   <= '0;
            htmr_q   <= '0;
            motor_q  <= 1'b0;
            hopper_q <= 1'b0;
            rej_a_q  <= 1'b0;
            rej_b_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_a_q  <= buf_a_d;
            buf_b_q  <= buf_b_d;
            ptr_q    <= ptr_d;
            coin_o_q <= coin_o_d;
            chg_q    <= chg_d;
            mtmr_q   <= mtmr_d;
            htmr_q   <= htmr_d;
            motor_q  <= motor_d;
            hopper_q <= hopper_d;
            rej_a_q  <= rej_a_d;
            rej_b_q  <= rej_b_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;
        ptr_d     = ptr_q;
        coin_o_d  = '0;
        chg_d     = chg_q;
        mtmr_d    = mtmr_q;
        htmr_d    = htmr_q;
        motor_d   = motor_q;
        hopper_d  = hopper_q;
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                // ptr_q = 0 favours A when both slots hold a coin
                if (full_a_c && (!full_b_c || !ptr_q)) begin
                    grant_a_c = 1'b1;
                    coin_o_d  = buf_a_q;
                    ptr_d     = 1'b1;
                    state_d   = ISSUE;
                end else if (full_b_c) begin
                    grant_b_c = 1'b1;
                    coin_o_d  = buf_b_q;
                    ptr_d     = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (sell_i) begin
                    chg_d   = change_i;
                    mtmr_d  = MOTOR_LOAD;
                    motor_d = 1'b1;
                    state_d = DISPENSE;
                end else begin
                    state_d = IDLE;
                end
            end
            DISPENSE: begin
                if (mtmr_q <= 8'd1) begin
                    mtmr_d  = '0;
                    motor_d = 1'b0;
                    if (chg_q != 2'b00) begin
                        htmr_d   = hop_load_c;
                        hopper_d = 1'b1;
                        state_d  = CHANGE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    mtmr_d = mtmr_q - 8'd1;
                end
            end
            CHANGE: begin
                if (htmr_q <= 8'd1) begin
                    htmr_d   = '0;
                    hopper_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    htmr_d = htmr_q - 8'd1;
                end
            end
            default: begin
                motor_d  = 1'b0;
                hopper_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // A slot being granted this edge frees its buffer for a coin arriving on the same edge
        if (legal_a_c && (!full_a_c || grant_a_c)) begin
            buf_a_d = coin_a;
        end else if (grant_a_c) begin
            buf_a_d = '0;
        end
        if (legal_b_c && (!full_b_c || grant_b_c)) begin
            buf_b_d = coin_b;
        end else if (grant_b_c) begin
            buf_b_d = '0;
        end

        rej_a_d = (coin_a == 2'b11) || (legal_a_c && full_a_c && !grant_a_c);
        rej_b_d = (coin_b == 2'b11) || (legal_b_c && full_b_c && !grant_b_c);
        busy_d  = (state_d != IDLE);
    end

    assign coin_o = coin_o_q;
    assign motor  = motor_q;
    assign hopper = hopper_q;
    assign rej_a  = rej_a_q;
    assign rej_b  = rej_b_q;
    assign busy   = busy_q;

`ifdef VEND_CTRL_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Completed sales, wrapping at 8 bits
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == CHECK) && sell_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign vend_cnt = cnt_q;
`else
    assign vend_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus pushes expected coin issues, sales,
// hopper runs and rejects; a negedge monitor pops and compares.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] coin_a = 2'b00;
    logic [1:0] coin_b = 2'b00;
    logic [1:0] coin_o;
    logic       sell_i;
    logic [1:0] change_i;
    logic       motor, hopper, rej_a, rej_b, busy;
    logic [7:0] vend_cnt;

    vend_ctrl #(.MOTOR_CYC(4), .HOPPER_CYC(2)) dut (
        .clk(clk), .rstn(rstn), .coin_a(coin_a), .coin_b(coin_b), .coin_o(coin_o),
        .sell_i(sell_i), .change_i(change_i), .motor(motor), .hopper(hopper),
        .rej_a(rej_a), .rej_b(rej_b), .busy(busy), .vend_cnt(vend_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: accumulates half-units, sells at 2.0 with registered sell/change
    int credit;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit   <= 0;
            sell_i   <= 1'b0;
            change_i <= 2'b00;
        end else if (coin_o != 2'b00) begin
            if (credit + int'(coin_o) >= 4) begin
                sell_i   <= 1'b1;
                change_i <= 2'(credit + int'(coin_o) - 4);
                credit   <= 0;
            end else begin
                sell_i   <= 1'b0;
                change_i <= 2'b00;
                credit   <= credit + int'(coin_o);
            end
        end else begin
            sell_i   <= 1'b0;
            change_i <= 2'b00;
        end
    end

    typedef struct { logic [1:0] code; int cyc; } coin_exp_t;
    typedef struct { int start; int mlen; logic [7:0] cnt; } sale_exp_t;
    typedef struct { bit slot_b; int cyc; } rej_exp_t;

    coin_exp_t coin_q[$];
    sale_exp_t sale_q[$];
    int        hop_q[$];
    rej_exp_t  rej_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int sales = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] cnt_exp(input int s);
`ifdef VEND_CTRL_CNT_EN
        return 8'(s);
`else
        return 8'd0;
`endif
    endfunction

    // Monitor
    initial begin
        logic [1:0] prev_coin;
        int m_len, m_start, h_len;
        logic [7:0] m_cnt;
        coin_exp_t ce;
        sale_exp_t se;
        rej_exp_t re;
        prev_coin = 0; m_len = 0; m_start = 0; h_len = 0; m_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_coin = 0; m_len = 0; h_len = 0;
            end else begin
                if (coin_o != 2'b00) begin
                    chk("coin_width", int'(prev_coin), 0);
                    if (coin_q.size() == 0) chk("coin_unexpected", int'(coin_o), 0);
                    else begin
                        ce = coin_q.pop_front();
                        chk("coin_code", int'(coin_o), int'(ce.code));
                        chk("coin_cycle", cyc, ce.cyc);
                    end
                end
                prev_coin = coin_o;
                if (motor) begin
                    if (m_len == 0) begin m_start = cyc; m_cnt = vend_cnt; end
                    m_len++;
                end else if (m_len > 0) begin
                    if (sale_q.size() == 0) chk("sale_unexpected", m_len, 0);
                    else begin
                        se = sale_q.pop_front();
                        chk("motor_start", m_start, se.start);
                        chk("motor_len", m_len, se.mlen);
                        chk("vend_cnt", int'(m_cnt), int'(se.cnt));
                    end
                    m_len = 0;
                end
                if (hopper) h_len++;
                else if (h_len > 0) begin
                    if (hop_q.size() == 0) chk("hopper_unexpected", h_len, 0);
                    else chk("hopper_len", h_len, hop_q.pop_front());
                    h_len = 0;
                end
                if (rej_a) begin
                    if (rej_q.size() == 0) chk("rej_a_unexpected", 1, 0);
                    else begin
                        re = rej_q.pop_front();
                        chk("rej_a_slot", int'(re.slot_b), 0);
                        chk("rej_a_cycle", cyc, re.cyc);
                    end
                end
                if (rej_b) begin
                    if (rej_q.size() == 0) chk("rej_b_unexpected", 1, 0);
                    else begin
                        re = rej_q.pop_front();
                        chk("rej_b_slot", int'(re.slot_b), 1);
                        chk("rej_b_cycle", cyc, re.cyc);
                    end
                end
            end
        end
    end

    // Caller sits at a negedge; coin is applied for exactly one rising edge
    task automatic put(input logic [1:0] a, input logic [1:0] b);
        coin_a = a;
        coin_b = b;
        @(negedge clk);
        coin_a = 2'b00;
        coin_b = 2'b00;
    endtask

    task automatic wait_idle();
        int run = 0;
        int n = 0;
        while (run < 3 && n < 300) begin
            @(negedge clk);
            n++;
            run = busy ? 0 : run + 1;
        end
        if (run < 3) chk("idle_timeout", n, -1);
    endtask

    task automatic push_coin(input logic [1:0] code, input int c);
        coin_q.push_back('{code, c});
    endtask

    task automatic push_sale(input int c, input int hlen);
        sales++;
        sale_q.push_back('{c + 4, 4, cnt_exp(sales)});
        if (hlen > 0) hop_q.push_back(hlen);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sales = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        do_reset();
        repeat (10) @(negedge clk);
        chk("rst_coin_o", int'(coin_o), 0);
        chk("rst_motor", int'(motor), 0);
        chk("rst_hopper", int'(hopper), 0);
        chk("rst_rej_a", int'(rej_a), 0);
        chk("rst_rej_b", int'(rej_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vend_cnt", int'(vend_cnt), 0);

        // A=1.0 then B=0.5 a cycle later; then A=1.0 completes a 2.5 credit sale
        c = cyc;
        push_coin(2'b10, c + 2);
        put(2'b10, 2'b00);
        push_coin(2'b01, c + 5);
        put(2'b00, 2'b01);
        wait_idle();
        c = cyc;
        push_coin(2'b10, c + 2);
        push_sale(c, 2);
        put(2'b10, 2'b00);
        wait_idle();
        chk("cnt_after_sale", int'(vend_cnt), int'(cnt_exp(1)));

        // Simultaneous coins: A first from a fresh pointer, then B first after an A grant
        do_reset();
        c = cyc;
        push_coin(2'b01, c + 2);
        push_coin(2'b10, c + 5);
        put(2'b01, 2'b10);
        wait_idle();
        c = cyc;
        push_coin(2'b01, c + 2);
        push_sale(c, 0);
        put(2'b01, 2'b00);
        wait_idle();
        c = cyc;
        push_coin(2'b10, c + 2);
        push_coin(2'b01, c + 5);
        put(2'b01, 2'b10);
        wait_idle();

        // Busy FSM: second A coin rejected, illegal B code rejected, buffered A issued after sale
        c = cyc;
        push_coin(2'b01, c + 2);
        push_sale(c, 0);
        put(2'b00, 2'b01);
        @(negedge clk);
        put(2'b10, 2'b00);
        rej_q.push_back('{1'b0, c + 4});
        rej_q.push_back('{1'b1, c + 4});
        push_coin(2'b10, c + 9);
        put(2'b10, 2'b11);
        wait_idle();

        // Reset during dispense with both buffers loaded
        c = cyc;
        push_coin(2'b10, c + 2);
        put(2'b10, 2'b00);
        repeat (4) @(negedge clk);
        chk("motor_before_rst", int'(motor), 1);
        put(2'b01, 2'b01);
        rstn = 1'b0;
        #1;
        chk("rst_mid_motor", int'(motor), 0);
        chk("rst_mid_hopper", int'(hopper), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_cnt", int'(vend_cnt), 0);
        sales = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        // 256 sales of 1.0 + 1.0: counter reaches 255 then wraps to 0
        for (int i = 0; i < 256; i++) begin
            c = cyc;
            push_coin(2'b10, c + 2);
            put(2'b10, 2'b00);
            wait_idle();
            c = cyc;
            push_coin(2'b10, c + 2);
            push_sale(c, 0);
            put(2'b10, 2'b00);
            wait_idle();
            if (i == 254) chk("cnt_255", int'(vend_cnt), int'(cnt_exp(255)));
        end
        chk("cnt_wrap", int'(vend_cnt), int'(cnt_exp(256)));

        repeat (5) @(negedge clk);
        chk("coin_q_left", coin_q.size(), 0);
        chk("sale_q_left", sale_q.size(), 0);
        chk("hop_q_left", hop_q.size(), 0);
        chk("rej_q_left", rej_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
